// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor sequencer around a single one-bit full-adder cell.
// Optional signed-overflow flag is compiled in when SERIAL_ADDSUB_OVF_EN is defined.
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-2:0] res_sr_q, res_sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;

    logic             fa_a_s, fa_b_s, fa_sum_s, fa_cout_s;
    logic [WIDTH-1:0] res_shift_s;
    logic             last_s;

    // One-bit full-adder cell; subtraction inverts B here and seeds the carry with 1.
    always_comb begin
        fa_a_s      = a_sr_q[0];
        fa_b_s      = b_sr_q[0] ^ mode_q;
        fa_sum_s    = fa_a_s ^ fa_b_s ^ carry_q;
        fa_cout_s   = (fa_a_s & fa_b_s) | (carry_q & (fa_a_s ^ fa_b_s));
        res_shift_s = {fa_sum_s, res_sr_q};
        last_s      = (state_q == S_SHIFT) && (cnt_q == LAST_BIT);
    end

    // Next-state and datapath sequencing.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        mode_d   = mode_q;
        result_d = result_q;
        cout_d   = cout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sr_d  = a_in;
                    b_sr_d  = b_in;
                    carry_d = mode;
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                res_sr_d = res_shift_s[WIDTH-1:1];
                carry_d  = fa_cout_s;
                cnt_d    = cnt_q + CW'(1);
                if (last_s) begin
                    result_d = res_shift_s;
                    cout_d   = fa_cout_s;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_SHIFT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            mode_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: carry into the MSB differs from the carry out of it.
    always_comb begin
        if (last_s) begin
            ovf_d = carry_q ^ fa_cout_s;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign busy      = (state_q == S_SHIFT);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: randomized and directed operations checked
// against an arithmetic reference model; honours SERIAL_ADDSUB_OVF_EN like the design.
module tb_serial_addsub_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   busy_run = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, longint got, longint exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Reference model: plain integer arithmetic on the operands.
    function automatic exp_t model(logic m, logic [W-1:0] a, logic [W-1:0] b);
        exp_t   e;
        longint ua, ub, sum, sa, sb, sv;
        ua = longint'(a);
        ub = longint'(b);
        sum = m ? (ua + ((longint'(1) <<< W) - ub)) : (ua + ub);
        e.res = W'(sum % (longint'(1) <<< W));
        e.c   = (sum >= (longint'(1) <<< W));
`ifdef SERIAL_ADDSUB_OVF_EN
        sa = (ua >= (longint'(1) <<< (W - 1))) ? ua - (longint'(1) <<< W) : ua;
        sb = (ub >= (longint'(1) <<< (W - 1))) ? ub - (longint'(1) <<< W) : ub;
        sv = m ? (sa - sb) : (sa + sb);
        e.v = (sv > (longint'(1) <<< (W - 1)) - 1) || (sv < -(longint'(1) <<< (W - 1)));
`else
        sa = 0; sb = 0; sv = 0;
        e.v = 1'b0;
`endif
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever done is presented.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_run = 0;
        end else begin
            chk("busy_done_exclusive", longint'(busy & done), 0);
            if (busy) busy_run++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", longint'(result), longint'(e.res));
                    chk("carry_out", longint'(carry_out), longint'(e.c));
                    chk("overflow", longint'(overflow), longint'(e.v));
                    chk("done_cycle", longint'(cyc), longint'(e.cyc));
                    chk("busy_cycles", longint'(busy_run), longint'(W));
                end
                busy_run = 0;
            end
        end
    end

    task automatic drive(logic m, logic [W-1:0] a, logic [W-1:0] b);
        start = 1'b1;
        mode  = m;
        a_in  = a;
        b_in  = b;
    endtask

    task automatic push_exp(logic m, logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        e = model(m, a, b);
        e.cyc = cyc + 1 + W;
        sb_q.push_back(e);
    endtask

    task automatic start_op(logic m, logic [W-1:0] a, logic [W-1:0] b);
        drive(m, a, b);
        push_exp(m, a, b);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4 * W; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) break;
        end
        if (sb_q.size() != 0) begin
            chk("done_timeout", longint'(sb_q.size()), 0);
            sb_q.delete();
        end
    endtask

    task automatic run_op(logic m, logic [W-1:0] a, logic [W-1:0] b);
        start_op(m, a, b);
        wait_done();
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_result"}, longint'(result), 0);
        chk({tag, "_carry"}, longint'(carry_out), 0);
        chk({tag, "_ovf"}, longint'(overflow), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        run_op(1'b0, 8'h35, 8'h1A);
        run_op(1'b0, 8'hFF, 8'h01);
        run_op(1'b1, 8'h10, 8'h01);
        run_op(1'b1, 8'h01, 8'h02);
        run_op(1'b0, 8'h7F, 8'h01);
        run_op(1'b1, 8'h80, 8'h01);
        run_op(1'b1, 8'h00, 8'h00);
        run_op(1'b0, 8'h80, 8'h80);

        // start pulsed mid-operation with different operands is ignored
        start_op(1'b0, 8'h35, 8'h1A);
        repeat (2) @(negedge clk);
        drive(1'b1, 8'hC3, 8'h5A);
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // start held high through DONE: next operation reloads immediately
        start_op(1'b0, 8'h12, 8'h34);
        repeat (W - 1) @(negedge clk);
        drive(1'b1, 8'hA0, 8'h0B);
        @(negedge clk);
        push_exp(1'b1, 8'hA0, 8'h0B);
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // reset during bit 4 aborts without a done pulse
        start_op(1'b0, 8'h55, 8'h66);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 3) @(negedge clk);
        run_op(1'b0, 8'h35, 8'h1A);

        for (int i = 0; i < 40; i++) begin
            logic         m;
            logic [W-1:0] a, b;
            m = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            run_op(m, a, b);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
